// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access path.
package dmem_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access-controller FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // Access sizes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Decode funct3 into an access size; unknown encodings behave as a word.
    // BU/HU only exist for loads, so for stores they fall into the word case.
    function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_store);
        logic [1:0] sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = is_store ? SZ_W : SZ_B;
            F3_HU:   sz = is_store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension of the load result
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_HU:   data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one bus request per load or
// store, stalls the pipeline until it completes, and reports faults as pulses.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] readData,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        exc_misalign,
    output logic        exc_bus
);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       f3_r;
    logic [1:0]       off_r;
    logic             load_r;
    logic             flushed_r;
    logic [31:0]      read_data_r;
    logic             bus_req_r;
    logic             bus_we_r;
    logic [31:0]      bus_addr_r;
    logic [31:0]      bus_wdata_r;
    logic [3:0]       bus_wstrb_r;

    logic             op_s;
    logic [1:0]       size_s;
    logic             misalign_s;
    logic             start_s;
    logic             timeout_s;
    logic             flushed_any_s;
    logic             stall_s;
    logic [31:0]      lane_wdata_s;
    logic [3:0]       lane_wstrb_s;
    logic [31:0]      load_data_s;

    assign op_s          = (memRead | memWrite) & ~flush;
    assign size_s        = access_size(funct3, memWrite);
    assign misalign_s    = is_misaligned(size_s, addr[1:0]);
    assign start_s       = (state_r == ST_IDLE) & op_s & ~misalign_s;
    assign timeout_s     = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    // A flush in the completing cycle counts the same as an earlier one
    assign flushed_any_s = flushed_r | flush;

    dmem_load_align u_load_align (
        .rdata  (bus_rdata),
        .offset (off_r),
        .funct3 (f3_r),
        .data   (load_data_s)
    );

    // Store data lane replication and byte enables for the incoming request
    always_comb begin
        lane_wdata_s = 32'h0000_0000;
        lane_wstrb_s = 4'b0000;
        if (memWrite) begin
            case (size_s)
                SZ_B: begin
                    lane_wdata_s = {4{wdata[7:0]}};
                    lane_wstrb_s = 4'b0001 << addr[1:0];
                end
                SZ_H: begin
                    lane_wdata_s = {2{wdata[15:0]}};
                    lane_wstrb_s = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    lane_wdata_s = wdata;
                    lane_wstrb_s = 4'b1111;
                end
            endcase
        end else begin
            lane_wdata_s = 32'h0000_0000;
            lane_wstrb_s = 4'b0000;
        end
    end

    // Stall covers the issuing IDLE cycle and every ACCESS cycle
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:   stall_s = op_s & ~misalign_s;
            ST_ACCESS: stall_s = 1'b1;
            default:   stall_s = 1'b0;
        endcase
    end

    // Access FSM, bus request registers, timeout counter and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            load_r      <= 1'b0;
            flushed_r   <= 1'b0;
            read_data_r <= 32'h0000_0000;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_wstrb_r <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_ACCESS;
                        cnt_r       <= '0;
                        f3_r        <= funct3;
                        off_r       <= addr[1:0];
                        load_r      <= memRead;
                        flushed_r   <= 1'b0;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= memWrite;
                        bus_addr_r  <= {addr[31:2], 2'b00};
                        bus_wdata_r <= lane_wdata_s;
                        bus_wstrb_r <= lane_wstrb_s;
                    end
                end
                ST_ACCESS: begin
                    if (flush) begin
                        flushed_r <= 1'b1;
                    end
                    if (bus_ready) begin
                        bus_req_r <= 1'b0;
                        if (flushed_any_s) begin
                            state_r <= ST_IDLE;
                        end else if (bus_err) begin
                            state_r     <= ST_ERR;
                            read_data_r <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_DONE;
                            if (load_r) begin
                                read_data_r <= load_data_s;
                            end
                        end
                    end else if (timeout_s) begin
                        bus_req_r <= 1'b0;
                        if (flushed_any_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r     <= ST_ERR;
                            read_data_r <= 32'h0000_0000;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is held
    assign stall        = reset_n & stall_s;
    assign exc_misalign = reset_n & (state_r == ST_IDLE) & op_s & misalign_s;
    assign exc_bus      = (state_r == ST_ERR);
    assign readData     = read_data_r;
    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_wdata    = bus_wdata_r;
    assign bus_wstrb    = bus_wstrb_r;

endmodule
